song_note_fetcher: RTL and testbench



---
 rtl/song_note_fetcher.sv | 112 +++++++++++
 tb/tb_song_note_fetcher.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_note_fetcher.sv
// Learn-mode note sequencer: fetches the selected song's notes from a synchronous ROM,
// blanks between notes so a repeated note needs a fresh key press, and flags end of song.
module song_note_fetcher #(
  parameter int         ADDR_W     = 8,
  parameter int         NOTE_LOG2  = 6,
  parameter logic [9:0] END_WORD   = 10'h000,
  parameter logic [9:0] BLANK_WORD = 10'h3FF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           song_sel,
  input  logic                 restart,
  input  logic                 read_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [9:0]           rom_data,
  output logic [9:0]           data_out,
  output logic                 note_valid,
  output logic                 song_done,
  output logic [NOTE_LOG2-1:0] note_index
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, LATCH, SHOW, DONE} state_t;

  localparam logic [NOTE_LOG2-1:0] LAST_NOTE = '1;

  state_t               state;
  logic [NOTE_LOG2-1:0] ptr;
  logic [1:0]           song_q;
  logic                 arm;
  logic                 read_en_q;

  // Song number occupies the top two address bits, the note pointer the bottom bits.
  function automatic logic [ADDR_W-1:0] song_addr(input logic [1:0] song,
                                                  input logic [NOTE_LOG2-1:0] p);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1 -: 2]   = song;
    a[NOTE_LOG2-1:0]   = p;
    return a;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      song_q     <= song_sel;
      rom_addr   <= song_addr(song_sel, '0);
      data_out   <= BLANK_WORD;
      note_valid <= 1'b0;
      song_done  <= 1'b0;
      note_index <= '0;
      arm        <= 1'b0;
      read_en_q  <= 1'b0;
    end else begin
      read_en_q <= read_en;
      // Restart beats everything, including an advance on the same edge.
      if (restart) begin
        song_q     <= song_sel;
        ptr        <= '0;
        note_index <= '0;
        song_done  <= 1'b0;
        note_valid <= 1'b0;
        data_out   <= BLANK_WORD;
        state      <= ISSUE;
      end else begin
        case (state)
          IDLE: if (read_en) state <= ISSUE;
          ISSUE: begin
            rom_addr <= song_addr(song_q, ptr);
            state    <= WAIT;
          end
          WAIT: state <= LATCH;
          LATCH: begin
            if (rom_data == END_WORD) begin
              song_done <= 1'b1;
              state     <= DONE;
            end else begin
              data_out   <= rom_data;
              note_valid <= 1'b1;
              arm        <= ~read_en;
              state      <= SHOW;
            end
          end
          SHOW: begin
            if (!read_en) arm <= 1'b1;
            // A key already held when the note appeared must be released before it counts.
            if (arm && read_en && !read_en_q) begin
              note_valid <= 1'b0;
              data_out   <= BLANK_WORD;
              arm        <= 1'b0;
              if (note_index != LAST_NOTE) note_index <= note_index + 1'b1;
              if (ptr == LAST_NOTE) begin
                song_done <= 1'b1;
                state     <= DONE;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= ISSUE;
              end
            end
          end
          DONE: begin
            song_done  <= 1'b1;
            note_valid <= 1'b0;
            data_out   <= BLANK_WORD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_note_fetcher.sv
// Bench for song_note_fetcher: directed stimulus pushes expected notes/end-of-song events
// into a scoreboard, and a monitor pops and compares them as the DUT presents them.
module tb_song_note_fetcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] song_sel;
  logic       restart;
  logic       read_en;
  logic [7:0] rom_addr;
  logic [9:0] rom_data;
  logic [9:0] data_out;
  logic       note_valid;
  logic       song_done;
  logic [5:0] note_index;

  song_note_fetcher dut (
    .clk(clk), .rst_n(rst_n), .song_sel(song_sel), .restart(restart), .read_en(read_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .data_out(data_out), .note_valid(note_valid),
    .song_done(song_done), .note_index(note_index)
  );

  always #5 clk = ~clk;

  logic [9:0] mem [256];
  always @(posedge clk) rom_data <= mem[rom_addr];

  typedef struct {
    bit         done;
    logic [9:0] data;
    int         index;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  bit   track  = 1'b0;
  bit   addr_escape = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic re, input logic rs, input int cycles);
    read_en = re;
    restart = rs;
    step(cycles);
  endtask

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("[TB] FAIL timeout: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: a rising note_valid or song_done is a DUT output event to be scored.
  bit prev_valid = 1'b0;
  bit prev_done  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (note_valid === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected_note: actual=0x%0h required=none", data_out);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_kind_note", 0, int'(e.done));
        checkOutput("sb_data", int'(data_out), int'(e.data));
        checkOutput("sb_index", int'(note_index), e.index);
      end
    end
    if (song_done === 1'b1 && !prev_done) begin
      if (sb.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected_done: actual=1 required=0");
      end else begin
        e = sb.pop_front();
        checkOutput("sb_kind_done", 1, int'(e.done));
        checkOutput("sb_done_index", int'(note_index), e.index);
      end
    end
    if (track && rom_addr[7:6] !== 2'd3) addr_escape = 1'b1;
    prev_valid = (note_valid === 1'b1);
    prev_done  = (song_done === 1'b1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 10'(i * 4 + 1);
    mem[64] = 10'h201;
    mem[65] = 10'h101;
    mem[66] = 10'h101;
    mem[67] = 10'h000;

    rst_n = 1'b0; song_sel = 2'd1; read_en = 1'b0; restart = 1'b0;
    step(3);
    checkOutput("rst_data", int'(data_out), 'h3FF);
    checkOutput("rst_valid", int'(note_valid), 0);
    checkOutput("rst_done", int'(song_done), 0);
    checkOutput("rst_index", int'(note_index), 0);
    checkOutput("rst_addr", int'(rom_addr), 'h40);

    // First note: one-cycle read_en after reset release, note shows 3 clk later.
    rst_n = 1'b1;
    sb.push_back('{1'b0, mem[64], 0});
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("issue_addr", int'(rom_addr), 'h40);
    checkOutput("fetch_blank", int'(data_out), 'h3FF);
    step(1);
    checkOutput("fetch_valid", int'(note_valid), 0);
    step(1);
    checkOutput("first_note", int'(data_out), 'h201);
    checkOutput("first_valid", int'(note_valid), 1);

    // Armed advance, key then held through the fetch.
    sb.push_back('{1'b0, mem[65], 1});
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("adv_blank1", int'(data_out), 'h3FF);
    checkOutput("adv_index", int'(note_index), 1);
    step(1);
    checkOutput("adv_blank2", int'(data_out), 'h3FF);
    checkOutput("adv_addr", int'(rom_addr), 'h41);
    step(1);
    checkOutput("adv_blank3", int'(data_out), 'h3FF);
    step(1);
    checkOutput("second_note", int'(data_out), 'h101);

    // Held key must not advance; release then press advances exactly once.
    step(3);
    checkOutput("held_index", int'(note_index), 1);
    checkOutput("held_valid", int'(note_valid), 1);
    applyStimulus(1'b0, 1'b0, 1);
    sb.push_back('{1'b0, mem[66], 2});
    read_en = 1'b1;
    waitDrain(20);
    step(5);
    checkOutput("repeat_held_index", int'(note_index), 2);
    checkOutput("repeat_held_valid", int'(note_valid), 1);
    applyStimulus(1'b0, 1'b0, 1);
    sb.push_back('{1'b1, 10'h000, 3});
    applyStimulus(1'b1, 1'b0, 1);
    read_en = 1'b0;
    waitDrain(20);
    checkOutput("end_data", int'(data_out), 'h3FF);
    checkOutput("end_valid", int'(note_valid), 0);

    // read_en ignored in DONE; restart to song 2.
    for (int i = 0; i < 4; i++) applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 1);
    read_en = 1'b0;
    checkOutput("done_stays", int'(song_done), 1);
    checkOutput("done_index", int'(note_index), 3);
    checkOutput("done_data", int'(data_out), 'h3FF);
    song_sel = 2'd2;
    sb.push_back('{1'b0, mem[128], 0});
    applyStimulus(1'b0, 1'b1, 1);
    restart = 1'b0;
    checkOutput("restart_done", int'(song_done), 0);
    checkOutput("restart_index", int'(note_index), 0);
    step(1);
    checkOutput("restart_addr", int'(rom_addr), 'h80);
    waitDrain(20);

    // Restart on the same edge as an advancing press: restart wins.
    song_sel = 2'd0;
    sb.push_back('{1'b0, mem[0], 0});
    applyStimulus(1'b1, 1'b1, 1);
    read_en = 1'b0; restart = 1'b0;
    checkOutput("collide_index", int'(note_index), 0);
    waitDrain(20);
    checkOutput("collide_data", int'(data_out), int'(mem[0]));

    // Full 64-note song without END_WORD.
    song_sel = 2'd3;
    sb.push_back('{1'b0, mem[192], 0});
    applyStimulus(1'b0, 1'b1, 1);
    restart = 1'b0;
    step(1);
    track = 1'b1;
    waitDrain(20);
    for (int i = 1; i < 64; i++) begin
      sb.push_back('{1'b0, mem[192 + i], i});
      applyStimulus(1'b1, 1'b0, 1);
      read_en = 1'b0;
      waitDrain(20);
    end
    sb.push_back('{1'b1, 10'h000, 63});
    applyStimulus(1'b1, 1'b0, 1);
    read_en = 1'b0;
    waitDrain(20);
    step(4);
    track = 1'b0;
    checkOutput("full_index_sat", int'(note_index), 63);
    checkOutput("full_last_addr", int'(rom_addr), 'hFF);
    checkOutput("full_addr_escape", int'(addr_escape), 0);
    checkOutput("full_done", int'(song_done), 1);

    // Reset asserted while the fetch is in its WAIT cycle.
    song_sel = 2'd1;
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    rst_n = 1'b0;
    step(1);
    checkOutput("midrst_data", int'(data_out), 'h3FF);
    checkOutput("midrst_valid", int'(note_valid), 0);
    checkOutput("midrst_index", int'(note_index), 0);
    checkOutput("midrst_addr", int'(rom_addr), 'h40);
    step(2);
    rst_n = 1'b1;
    step(6);
    checkOutput("midrst_idle_valid", int'(note_valid), 0);
    checkOutput("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
